// File: rtl/proc_control_unit.sv
// Multi-cycle control sequencer for the cs147sec05 datapath: INIT/FETCH/DECODE/EXE/MEM/WB.
// Optional feature macro PROC_CTRL_HALT_ON_UNKNOWN_EN: unknown encodings trap in HALT instead of acting as NOP.
module proc_control_unit #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [31:0] CTRL,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXE    = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd7
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT);

`ifdef PROC_CTRL_HALT_ON_UNKNOWN_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [1:0]  wait_cnt, wait_nxt;
    logic [31:0] ctrl_nxt;
    logic        rd_nxt, wr_nxt;

    logic [5:0] opcode, funct;
    logic       unused_instr_bits;
    assign opcode            = INSTRUCTION[31:26];
    assign funct             = INSTRUCTION[5:0];
    assign unused_instr_bits = ^INSTRUCTION[25:6];

    logic       r_alu, r_shift, r_jr, i_alu_s, i_alu_z, is_br, is_lw, is_sw;
    logic       is_push, is_pop, is_lui, is_jmp, is_jal, known, br_taken;
    logic [5:0] alu_oprn;

    always_comb begin
        r_alu    = 1'b0;
        r_shift  = 1'b0;
        r_jr     = 1'b0;
        alu_oprn = 6'd0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20: begin r_alu = 1'b1;   alu_oprn = 6'd1; end
                6'h22: begin r_alu = 1'b1;   alu_oprn = 6'd2; end
                6'h2c: begin r_alu = 1'b1;   alu_oprn = 6'd3; end
                6'h24: begin r_alu = 1'b1;   alu_oprn = 6'd6; end
                6'h25: begin r_alu = 1'b1;   alu_oprn = 6'd7; end
                6'h27: begin r_alu = 1'b1;   alu_oprn = 6'd8; end
                6'h2a: begin r_alu = 1'b1;   alu_oprn = 6'd9; end
                6'h01: begin r_shift = 1'b1; alu_oprn = 6'd5; end
                6'h02: begin r_shift = 1'b1; alu_oprn = 6'd4; end
                6'h08: r_jr = 1'b1;
                default: ;
            endcase
        end
        i_alu_s = (opcode == 6'h08) || (opcode == 6'h1d) || (opcode == 6'h0a);
        i_alu_z = (opcode == 6'h0c) || (opcode == 6'h0d);
        is_br   = (opcode == 6'h04) || (opcode == 6'h05);
        is_lw   = (opcode == 6'h23);
        is_sw   = (opcode == 6'h2b);
        is_push = (opcode == 6'h1b);
        is_pop  = (opcode == 6'h1c);
        is_lui  = (opcode == 6'h0f);
        is_jmp  = (opcode == 6'h02);
        is_jal  = (opcode == 6'h03);
        case (opcode)
            6'h08, 6'h23, 6'h2b, 6'h1c: alu_oprn = 6'd1;
            6'h04, 6'h05, 6'h1b:        alu_oprn = 6'd2;
            6'h1d:                      alu_oprn = 6'd3;
            6'h0a:                      alu_oprn = 6'd9;
            6'h0c:                      alu_oprn = 6'd6;
            6'h0d:                      alu_oprn = 6'd7;
            default: ;
        endcase
        known = r_alu | r_shift | r_jr | i_alu_s | i_alu_z | is_br | is_lw | is_sw
              | is_push | is_pop | is_lui | is_jmp | is_jal;
        br_taken = ((opcode == 6'h04) && ZERO) || ((opcode == 6'h05) && !ZERO);
    end

    // Per-state output words; the FSM below registers the one for the state being entered.
    logic [31:0] fetch_ctrl, decode_ctrl, exe_ctrl, mem_ctrl, wb_ctrl;
    logic        fetch_last, mem_rd, mem_wr, wb_rd;

    always_comb begin
        fetch_ctrl     = '0;
        fetch_ctrl[28] = 1'b1;
        fetch_ctrl[1]  = fetch_last;

        decode_ctrl     = '0;
        decode_ctrl[4]  = 1'b1;
        decode_ctrl[14] = is_push | is_pop;

        exe_ctrl       = '0;
        exe_ctrl[4]    = 1'b1;
        exe_ctrl[10:5] = alu_oprn;
        if (r_alu || is_br)               exe_ctrl[25] = 1'b1;
        if (r_shift)                      exe_ctrl[24] = 1'b1;
        if (i_alu_s || is_lw || is_sw)    exe_ctrl[23] = 1'b1;
        if (is_push || is_pop) begin
            exe_ctrl[21] = 1'b1;
            exe_ctrl[24] = 1'b1;
            exe_ctrl[22] = 1'b1;
        end

        mem_ctrl = '0;
        mem_rd   = is_lw;
        mem_wr   = is_sw | is_push;
        if (is_push) begin
            mem_ctrl[27] = 1'b1;
            mem_ctrl[26] = 1'b1;
        end
        if (is_push || is_pop) mem_ctrl[2] = 1'b1;

        wb_ctrl     = '0;
        wb_rd       = is_pop;
        wb_ctrl[0]  = 1'b1;
        wb_ctrl[11] = ~r_jr;
        wb_ctrl[12] = br_taken;
        wb_ctrl[13] = ~(is_jmp | is_jal);
        if (r_alu || r_shift) begin
            wb_ctrl[3]  = 1'b1;
            wb_ctrl[17] = 1'b1;
        end
        if (i_alu_s || i_alu_z) begin
            wb_ctrl[3]  = 1'b1;
            wb_ctrl[15] = 1'b1;
        end
        if (is_lw || is_pop) begin
            wb_ctrl[3]  = 1'b1;
            wb_ctrl[15] = 1'b1;
            wb_ctrl[20] = 1'b1;
            wb_ctrl[18] = 1'b1;
        end
        if (is_pop) wb_ctrl[27] = 1'b1;
        if (is_lui) begin
            wb_ctrl[3]  = 1'b1;
            wb_ctrl[15] = 1'b1;
            wb_ctrl[19] = 1'b1;
        end
        if (is_jal) begin
            wb_ctrl[3]  = 1'b1;
            wb_ctrl[16] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        ctrl_nxt   = '0;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        fetch_last = (WAIT_LAST == 2'd0);
        case (state)
            INIT, WB: begin
                state_nxt = FETCH;
                wait_nxt  = '0;
                ctrl_nxt  = fetch_ctrl;
                rd_nxt    = 1'b1;
            end
            FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = DECODE;
                    wait_nxt  = '0;
                    ctrl_nxt  = decode_ctrl;
                end else begin
                    wait_nxt   = 2'(wait_cnt + 2'd1);
                    fetch_last = (2'(wait_cnt + 2'd1) == WAIT_LAST);
                    ctrl_nxt   = fetch_ctrl;
                    rd_nxt     = 1'b1;
                end
            end
            DECODE: begin
                if (HALT_EN && !known) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = EXE;
                    ctrl_nxt  = exe_ctrl;
                end
            end
            EXE: begin
                state_nxt = MEM;
                ctrl_nxt  = mem_ctrl;
                rd_nxt    = mem_rd;
                wr_nxt    = mem_wr;
            end
            MEM: begin
                state_nxt = WB;
                ctrl_nxt  = wb_ctrl;
                rd_nxt    = wb_rd;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= INIT;
            wait_cnt  <= '0;
            CTRL      <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            CTRL      <= ctrl_nxt;
            MEM_READ  <= rd_nxt;
            MEM_WRITE <= wr_nxt;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_proc_control_unit.sv
// Randomized self-checking bench for proc_control_unit against an instruction-level reference model.
module tb_proc_control_unit;

    localparam int unsigned FW = 0;
`ifdef PROC_CTRL_HALT_ON_UNKNOWN_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        CLK, RST, ZERO, MEM_READ, MEM_WRITE;
    logic [31:0] INSTRUCTION, CTRL;
    logic [2:0]  STATE;

    int asserts_cnt = 0;
    int fail_cnt    = 0;

    proc_control_unit #(.FETCH_WAIT(FW)) dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .CTRL(CTRL), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .STATE(STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum int {K_RALU, K_SHIFT, K_JR, K_IS, K_IZ, K_BEQ, K_BNE, K_LW, K_SW,
                      K_PUSH, K_POP, K_LUI, K_JMP, K_JAL, K_UNK} kind_t;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a}) return K_RALU;
            if (fn inside {6'h01, 6'h02}) return K_SHIFT;
            if (fn == 6'h08) return K_JR;
            return K_UNK;
        end
        case (op)
            6'h08, 6'h1d, 6'h0a: return K_IS;
            6'h0c, 6'h0d:        return K_IZ;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h1b: return K_PUSH;
            6'h1c: return K_POP;
            6'h0f: return K_LUI;
            6'h02: return K_JMP;
            6'h03: return K_JAL;
            default: return K_UNK;
        endcase
    endfunction

    // Operation named by mnemonic, mapped to the ALU opcode table.
    function automatic int oprn_of(input logic [31:0] ins);
        string mn;
        int    tbl[string];
        tbl = '{"add":1, "sub":2, "mul":3, "shr":4, "shl":5, "and":6, "or":7, "nor":8, "slt":9, "none":0};
        mn = "none";
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: mn = "add";  6'h22: mn = "sub";  6'h2c: mn = "mul";
                6'h24: mn = "and";  6'h25: mn = "or";   6'h27: mn = "nor";
                6'h2a: mn = "slt";  6'h01: mn = "shl";  6'h02: mn = "shr";
                default: mn = "none";
            endcase
        end else begin
            case (ins[31:26])
                6'h08, 6'h23, 6'h2b, 6'h1c: mn = "add";
                6'h1d: mn = "mul";
                6'h0a: mn = "slt";
                6'h0c: mn = "and";
                6'h0d: mn = "or";
                6'h04, 6'h05, 6'h1b: mn = "sub";
                default: mn = "none";
            endcase
        end
        return tbl[mn];
    endfunction

    // Expected {MEM_READ, MEM_WRITE, CTRL} for phase 1..5 (FETCH..WB).
    function automatic logic [33:0] model_out(input int ph, input logic [31:0] ins,
                                              input logic z, input bit last_fetch);
        kind_t k;
        logic [31:0] c;
        logic rd, wr;
        k = kind_of(ins);
        c = '0; rd = 1'b0; wr = 1'b0;
        case (ph)
            1: begin rd = 1'b1; c[28] = 1'b1; c[1] = last_fetch; end
            2: begin c[4] = 1'b1; c[14] = (k == K_PUSH || k == K_POP); end
            3: begin
                c[4] = 1'b1;
                c[10:5] = 6'(oprn_of(ins));
                case (k)
                    K_RALU, K_BEQ, K_BNE: c[25] = 1'b1;
                    K_SHIFT:              c[24] = 1'b1;
                    K_IS, K_LW, K_SW:     c[23] = 1'b1;
                    K_PUSH, K_POP:        begin c[21] = 1'b1; c[24] = 1'b1; c[22] = 1'b1; end
                    default: ;
                endcase
            end
            4: case (k)
                K_LW:   rd = 1'b1;
                K_SW:   wr = 1'b1;
                K_PUSH: begin wr = 1'b1; c[27] = 1'b1; c[26] = 1'b1; c[2] = 1'b1; end
                K_POP:  c[2] = 1'b1;
                default: ;
            endcase
            5: begin
                c[0] = 1'b1; c[11] = 1'b1; c[13] = 1'b1;
                case (k)
                    K_RALU, K_SHIFT: begin c[3] = 1'b1; c[17] = 1'b1; end
                    K_IS, K_IZ:      begin c[3] = 1'b1; c[15] = 1'b1; end
                    K_LW:  begin c[3] = 1'b1; c[15] = 1'b1; c[20] = 1'b1; c[18] = 1'b1; end
                    K_POP: begin c[3] = 1'b1; c[15] = 1'b1; c[20] = 1'b1; c[18] = 1'b1;
                                 c[27] = 1'b1; rd = 1'b1; end
                    K_LUI: begin c[3] = 1'b1; c[15] = 1'b1; c[19] = 1'b1; end
                    K_BEQ: c[12] = z;
                    K_BNE: c[12] = ~z;
                    K_JR:  c[11] = 1'b0;
                    K_JMP: c[13] = 1'b0;
                    K_JAL: begin c[13] = 1'b0; c[3] = 1'b1; c[16] = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {rd, wr, c};
    endfunction

    task automatic check_all(input string tag, input int st, input logic [33:0] e);
        check_val({tag, "_state"}, 32'(STATE), 32'(st));
        check_val({tag, "_ctrl"},  CTRL, e[31:0]);
        check_val({tag, "_rd"},    32'(MEM_READ), 32'(e[33]));
        check_val({tag, "_wr"},    32'(MEM_WRITE), 32'(e[32]));
    endtask

    task automatic async_reset(input string tag);
        #2 RST = 1'b0;
        #1 check_all({tag, "_async_rst"}, 0, '0);
        @(negedge CLK);
        check_all({tag, "_rst_held"}, 0, '0);
        RST = 1'b1;
    endtask

    // Runs one instruction from INIT/WB; abort_ph>0 asserts reset after that phase.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z, input int abort_ph);
        INSTRUCTION = ins;
        ZERO        = z;
        for (int i = 0; i <= int'(FW); i++) begin
            @(posedge CLK); @(negedge CLK);
            check_all({tag, "_fetch"}, 1, model_out(1, ins, z, i == int'(FW)));
        end
        for (int ph = 2; ph <= 5; ph++) begin
            @(posedge CLK); @(negedge CLK);
            if (ph == 3 && HALT_EN && kind_of(ins) == K_UNK) begin
                for (int j = 0; j < 3; j++) begin
                    check_all({tag, "_halt"}, 7, '0);
                    @(posedge CLK); @(negedge CLK);
                end
                async_reset(tag);
                return;
            end
            check_all($sformatf("%s_ph%0d", tag, ph), ph, model_out(ph, ins, z, 1'b0));
            if (ph == abort_ph) begin
                async_reset(tag);
                return;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h1d, 6'h0a, 6'h0c, 6'h0d, 6'h04,
                              6'h05, 6'h23, 6'h2b, 6'h1b, 6'h1c, 6'h0f, 6'h02, 6'h03, 6'h3f, 6'h11};
        logic [5:0] fns[] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02,
                              6'h08, 6'h3f};
        logic [31:0] r;
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, ops.size() - 1)];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, fns.size() - 1)];
        return r;
    endfunction

    initial begin
        RST = 1'b0; INSTRUCTION = '0; ZERO = 1'b0;
        #1 check_all("reset", 0, '0);
        repeat (2) @(negedge CLK);
        check_all("reset_hold", 0, '0);
        RST = 1'b1;

        run_instr("add",     {6'h00, 20'h12345, 6'h20}, 1'b0, 0);
        run_instr("lw",      {6'h23, 26'h0abcdef},      1'b0, 0);
        run_instr("beq_z1",  {6'h04, 26'h0000010},      1'b1, 0);
        run_instr("beq_z0",  {6'h04, 26'h0000010},      1'b0, 0);
        run_instr("bne_z0",  {6'h05, 26'h0000010},      1'b0, 0);
        run_instr("push",    {6'h1b, 26'h0},            1'b0, 0);
        run_instr("pop",     {6'h1c, 26'h0},            1'b1, 0);
        run_instr("unk",     {6'h3f, 26'h3ffffff},      1'b0, 0);
        run_instr("abort_exe", {6'h00, 20'h0, 6'h20},   1'b0, 3);
        run_instr("after_rst", {6'h3f, 26'h0},          1'b0, 0);
        run_instr("abort_sw",  {6'h2b, 26'h1},          1'b0, 4);
        run_instr("jal",     {6'h03, 26'h0000100},      1'b0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] ins;
            ins = rand_instr();
            run_instr($sformatf("rnd%0d_op%02h", n, ins[31:26]), ins, 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
        $finish;
    end

endmodule
